// File: rtl/exec_stage_ctrl.sv
// rtl/exec_stage_ctrl.sv - Y86 execute stage: ALU operand/function select, CC register, Cnd, registered output handshake (optional perf counters: EXEC_PERF_CNT_EN)
module exec_stage_ctrl #(
    parameter int W      = 64,
    parameter int STAT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [W-1:0]      in_valA,
    input  logic [W-1:0]      in_valB,
    input  logic [W-1:0]      in_valC,
    input  logic [STAT_W-1:0] in_stat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [W-1:0]      out_valE,
    output logic [W-1:0]      out_valA,
    output logic              out_cnd,
    output logic [STAT_W-1:0] out_stat,
    output logic [2:0]        cc_flags
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_instr,
    output logic [31:0]       perf_stall
`endif
);

    // Y86 instruction codes used by the operand and condition logic
    localparam logic [3:0] IC_CMOVQ  = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    // Stack pointer adjustments: -8 is the two's complement of 8 (~7)
    localparam logic [W-1:0] C_PLUS8  = W'(8);
    localparam logic [W-1:0] C_MINUS8 = ~(W'(7));

    // CC bit positions within {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic [3:0]          r_out_icode;
    logic [W-1:0]        r_out_valE;
    logic [W-1:0]        r_out_valA;
    logic                r_out_cnd;
    logic [STAT_W-1:0]   r_out_stat;
    logic [2:0]          r_cc;

    logic                w_in_ready;
    logic                w_accept;
    logic [W-1:0]        w_alu_a;
    logic [W-1:0]        w_alu_b;
    alu_fn_t             w_alu_fn;
    logic [W-1:0]        w_alu_r;
    logic                w_alu_of;
    logic [2:0]          w_cc_next;
    logic                w_cc_we;
    logic                w_cond;
    logic                w_cnd;
    logic                w_zf;
    logic                w_sf;
    logic                w_of;

    // The stage can take a new instruction when empty, or when the held result leaves this cycle
    assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // ALU operand A: valA for register ops, valC for immediates/displacements, +/-8 for stack ops
    always_comb begin
        w_alu_a = '0;
        case (in_icode)
            IC_CMOVQ, IC_OPQ:                 w_alu_a = in_valA;
            IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ:  w_alu_a = in_valC;
            IC_CALL, IC_PUSHQ:                w_alu_a = C_MINUS8;
            IC_RET, IC_POPQ:                  w_alu_a = C_PLUS8;
            default:                          w_alu_a = '0;
        endcase
    end

    // ALU operand B: valB for memory/stack/arith ops, zero for moves so valE = operand A
    always_comb begin
        w_alu_b = '0;
        case (in_icode)
            IC_RMMOVQ, IC_MRMOVQ, IC_OPQ,
            IC_CALL, IC_RET, IC_PUSHQ, IC_POPQ: w_alu_b = in_valB;
            default:                            w_alu_b = '0;
        endcase
    end

    // ALU function: only OPq chooses via ifun; unknown ifun values fall back to add
    always_comb begin
        w_alu_fn = ALU_ADD;
        if (in_icode == IC_OPQ) begin
            case (in_ifun)
                4'h1:    w_alu_fn = ALU_SUB;
                4'h2:    w_alu_fn = ALU_AND;
                4'h3:    w_alu_fn = ALU_XOR;
                default: w_alu_fn = ALU_ADD;
            endcase
        end
    end

    // ALU datapath with signed overflow detection; sub computes B-A
    always_comb begin
        w_alu_r  = '0;
        w_alu_of = 1'b0;
        case (w_alu_fn)
            ALU_ADD: begin
                w_alu_r  = w_alu_b + w_alu_a;
                w_alu_of = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_alu_r[W-1] != w_alu_a[W-1]);
            end
            ALU_SUB: begin
                w_alu_r  = w_alu_b - w_alu_a;
                w_alu_of = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_alu_r[W-1] != w_alu_b[W-1]);
            end
            ALU_AND: w_alu_r = w_alu_b & w_alu_a;
            ALU_XOR: w_alu_r = w_alu_b ^ w_alu_a;
            default: w_alu_r = '0;
        endcase
    end

    assign w_cc_next = {(w_alu_r == '0), w_alu_r[W-1], w_alu_of};

    // Only an OPq with good status updates the flags, and only on the cycle it is accepted
    assign w_cc_we = w_accept && (in_icode == IC_OPQ) && (in_stat == '0);

    assign w_zf = r_cc[CC_ZF];
    assign w_sf = r_cc[CC_SF];
    assign w_of = r_cc[CC_OF];

    // Branch/move condition from the flags as they stand before this acceptance edge
    always_comb begin
        w_cond = 1'b0;
        case (in_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (w_sf ^ w_of) | w_zf;
            4'h2:    w_cond = w_sf ^ w_of;
            4'h3:    w_cond = w_zf;
            4'h4:    w_cond = ~w_zf;
            4'h5:    w_cond = ~(w_sf ^ w_of);
            4'h6:    w_cond = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cond = 1'b0;
        endcase
    end

    // Cnd is meaningful only for cmovXX and jXX
    assign w_cnd = ((in_icode == IC_CMOVQ) || (in_icode == IC_JXX)) ? w_cond : 1'b0;

    // Output FSM: loads the result register on acceptance, drains it when memory takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_icode <= '0;
            r_out_valE  <= '0;
            r_out_valA  <= '0;
            r_out_cnd   <= 1'b0;
            r_out_stat  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_out_icode <= in_icode;
                        r_out_valE  <= w_alu_r;
                        r_out_valA  <= in_valA;
                        r_out_cnd   <= w_cnd;
                        r_out_stat  <= in_stat;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            r_out_valid <= 1'b1;
                            r_out_icode <= in_icode;
                            r_out_valE  <= w_alu_r;
                            r_out_valA  <= in_valA;
                            r_out_cnd   <= w_cnd;
                            r_out_stat  <= in_stat;
                        end else begin
                            r_state     <= ST_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Condition-code register; resets to ZF=1 so an initial "je" is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_cc_we) begin
            r_cc <= w_cc_next;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;

    // Free-running wrap-around counters of accepted instructions and stalled output cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_instr <= r_perf_instr + 32'd1;
            end
            if (r_out_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_icode = r_out_icode;
    assign out_valE  = r_out_valE;
    assign out_valA  = r_out_valA;
    assign out_cnd   = r_out_cnd;
    assign out_stat  = r_out_stat;
    assign cc_flags  = r_cc;

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// tb/tb_exec_stage_ctrl.sv - directed self-checking bench for exec_stage_ctrl
module tb_exec_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [63:0] in_valA;
    logic [63:0] in_valB;
    logic [63:0] in_valC;
    logic [1:0]  in_stat;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] out_valA;
    logic        out_cnd;
    logic [1:0]  out_stat;
    logic [2:0]  cc_flags;

    int n_cmp;
    int n_fail;

    exec_stage_ctrl #(.W(64), .STAT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_icode  (in_icode),
        .in_ifun   (in_ifun),
        .in_valA   (in_valA),
        .in_valB   (in_valB),
        .in_valC   (in_valC),
        .in_stat   (in_stat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_valE  (out_valE),
        .out_valA  (out_valA),
        .out_cnd   (out_cnd),
        .out_stat  (out_stat),
        .cc_flags  (cc_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [1:0] st);
        in_icode = ic;
        in_ifun  = fn;
        in_valA  = a;
        in_valB  = b;
        in_valC  = c;
        in_stat  = st;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", out_valid); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b100) begin $display("FAIL reset_cc got=%b exp=100", cc_flags); n_fail++; end
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b exp=1", in_ready); n_fail++; end
        n_cmp++; if (out_valE !== 64'h0) begin $display("FAIL reset_valE got=%h exp=0", out_valE); n_fail++; end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_opq_sub();
        put(4'h6, 4'h1, 64'd3, 64'd5, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'd2) begin $display("FAIL sub_5m3_valE got=%h exp=2", out_valE); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b000) begin $display("FAIL sub_5m3_cc got=%b exp=000", cc_flags); n_fail++; end
        put(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin $display("FAIL sub_valid got=%b exp=1", out_valid); n_fail++; end
        n_cmp++; if (out_valE !== 64'd0) begin $display("FAIL sub_valE got=%h exp=0", out_valE); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b100) begin $display("FAIL sub_cc got=%b exp=100", cc_flags); n_fail++; end
        n_cmp++; if (out_cnd !== 1'b0) begin $display("FAIL sub_cnd got=%b exp=0", out_cnd); n_fail++; end
        put(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 2'd0);
        tick();
        n_cmp++; if (out_cnd !== 1'b1) begin $display("FAIL je_cnd got=%b exp=1", out_cnd); n_fail++; end
        n_cmp++; if (out_icode !== 4'h7) begin $display("FAIL je_icode got=%h exp=7", out_icode); n_fail++; end
        put(4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 2'd0);
        tick();
        n_cmp++; if (out_cnd !== 1'b0) begin $display("FAIL jne_cnd got=%b exp=0", out_cnd); n_fail++; end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL drain_valid got=%b exp=0", out_valid); n_fail++; end
    endtask

    task automatic test_overflow();
        put(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin $display("FAIL ovf_valE got=%h exp=fffffffffffffffe", out_valE); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b011) begin $display("FAIL ovf_cc got=%b exp=011", cc_flags); n_fail++; end
        put(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_cnd !== 1'b0) begin $display("FAIL jl_cnd got=%b exp=0", out_cnd); n_fail++; end
        put(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_cnd !== 1'b1) begin $display("FAIL jge_cnd got=%b exp=1", out_cnd); n_fail++; end
        put(4'h2, 4'h6, 64'h55, 64'h99, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_cnd !== 1'b1) begin $display("FAIL cmovg_cnd got=%b exp=1", out_cnd); n_fail++; end
        n_cmp++; if (out_valE !== 64'h55) begin $display("FAIL cmovg_valE got=%h exp=55", out_valE); n_fail++; end
        n_cmp++; if (out_valA !== 64'h55) begin $display("FAIL cmovg_valA got=%h exp=55", out_valA); n_fail++; end
    endtask

    task automatic test_stack();
        put(4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'hF8) begin $display("FAIL push_valE got=%h exp=f8", out_valE); n_fail++; end
        n_cmp++; if (out_cnd !== 1'b0) begin $display("FAIL push_cnd got=%b exp=0", out_cnd); n_fail++; end
        put(4'hB, 4'h0, 64'h0, 64'h100, 64'd0, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'h108) begin $display("FAIL pop_valE got=%h exp=108", out_valE); n_fail++; end
        put(4'h3, 4'h0, 64'h0, 64'h999, 64'h1234, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'h1234) begin $display("FAIL irmov_valE got=%h exp=1234", out_valE); n_fail++; end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (cc_flags !== 3'b011) begin $display("FAIL stack_cc got=%b exp=011", cc_flags); n_fail++; end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        put(4'h3, 4'h0, 64'd0, 64'd0, 64'd1, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'd1) begin $display("FAIL bp_first_valE got=%h exp=1", out_valE); n_fail++; end
        put(4'h3, 4'h0, 64'd0, 64'd0, 64'd2, 2'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); n_fail++; end
            tick();
            n_cmp++; if (out_valE !== 64'd1 || out_valid !== 1'b1) begin
                $display("FAIL bp_hold[%0d] got valE=%h valid=%b exp valE=1 valid=1", i, out_valE, out_valid); n_fail++; end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got=%b exp=1", in_ready); n_fail++; end
        tick();
        n_cmp++; if (out_valE !== 64'd2) begin $display("FAIL bp_second_valE got=%h exp=2", out_valE); n_fail++; end
        put(4'h3, 4'h0, 64'd0, 64'd0, 64'd3, 2'd0);
        tick();
        n_cmp++; if (out_valE !== 64'd3) begin $display("FAIL bp_third_valE got=%h exp=3", out_valE); n_fail++; end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain_valid got=%b exp=0", out_valid); n_fail++; end
    endtask

    task automatic test_status();
        put(4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 2'd2);
        tick();
        n_cmp++; if (out_valE !== 64'd0) begin $display("FAIL stat_valE got=%h exp=0", out_valE); n_fail++; end
        n_cmp++; if (out_stat !== 2'd2) begin $display("FAIL stat_pass got=%0d exp=2", out_stat); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b011) begin $display("FAIL stat_cc got=%b exp=011", cc_flags); n_fail++; end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        put(4'h3, 4'h0, 64'd0, 64'd0, 64'hAA, 2'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin $display("FAIL mid_full_valid got=%b exp=1", out_valid); n_fail++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL mid_reset_valid got=%b exp=0", out_valid); n_fail++; end
        n_cmp++; if (cc_flags !== 3'b100) begin $display("FAIL mid_reset_cc got=%b exp=100", cc_flags); n_fail++; end
        n_cmp++; if (out_valE !== 64'd0) begin $display("FAIL mid_reset_valE got=%h exp=0", out_valE); n_fail++; end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL post_reset_ready got=%b exp=1", in_ready); n_fail++; end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_icode  = 4'h0;
        in_ifun   = 4'h0;
        in_valA   = 64'd0;
        in_valB   = 64'd0;
        in_valC   = 64'd0;
        in_stat   = 2'd0;
        out_ready = 1'b1;
        test_reset();
        test_opq_sub();
        test_overflow();
        test_stack();
        test_backpressure();
        test_status();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
